// File: rtl/pic_pkg.sv
// pic_pkg: shared types, constants and rotate/index helpers for the PIC request/service stage
package pic_pkg;
  typedef enum logic {IDLE, WAIT2} ack_state_e;
  localparam int PIC_LEVELS = 8;
  localparam logic [2:0] SPURIOUS_LEVEL = 3'd7;
  function automatic logic [7:0] rotate_right8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} >> n;
    return d[7:0];
  endfunction
  function automatic logic [7:0] rotate_left8(input logic [7:0] x, input logic [2:0] n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction
  function automatic logic [2:0] onehot_to_idx3(input logic [7:0] x);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < PIC_LEVELS; i++) if (x[i]) idx = i[2:0];
    return idx;
  endfunction
endpackage

// File: rtl/pic_priority_resolver.sv
// pic_priority_resolver: rotate right, pick lowest set bit, report it one-hot (unrotated) and by rotated index
module pic_priority_resolver
  import pic_pkg::*;
(
  input  logic [7:0] i_vec,
  input  logic [2:0] i_amt,
  output logic [7:0] o_onehot,
  output logic [2:0] o_rot_idx,
  output logic       o_any
);
  logic [7:0] w_rot, w_low;
  assign w_rot     = rotate_right8(i_vec, i_amt);
  assign w_low     = w_rot & (~w_rot + 8'd1);
  assign o_onehot  = rotate_left8(w_low, i_amt);
  assign o_rot_idx = onehot_to_idx3(w_low);
  assign o_any     = |i_vec;
endmodule

// File: rtl/pic_request_service.sv
// pic_request_service: IRR latching, rotating priority, INT generation and two-pulse INTA sequencing
module pic_request_service
  import pic_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       level_edge_triggered,
  input  logic [7:0] int_mask,
  input  logic [7:0] eoi,
  input  logic [2:0] priority_rotate,
  input  logic       auto_eoi,
  input  logic [4:0] vector_base,
  input  logic       int_ack,
  output logic       INT,
  output logic [7:0] irr,
  output logic [7:0] isr,
  output logic [7:0] highest_level_in_service,
  output logic [7:0] acknowledge_interrupt,
  output logic       end_of_ack_seq,
  output logic [7:0] vector,
  output logic       vector_valid
);
  ack_state_e r_state, w_state_next;
  logic [7:0] r_irr, r_isr, r_ir_prev, r_ack, r_vector;
  logic       r_int, r_vv, r_int_ack_q, r_spur;
  logic [2:0] r_level, w_level, w_amt, w_req_idx, w_isr_idx;
  logic [7:0] w_req, w_req_oh, w_isr_oh, w_set, w_aeoi_clr, w_rise;
  logic       w_req_any, w_isr_any, w_eligible, w_ack_rise, w_first, w_second;
  assign w_amt = priority_rotate + 3'd1;
  assign w_req = r_irr & ~int_mask;
  pic_priority_resolver u_req (.i_vec(w_req), .i_amt(w_amt), .o_onehot(w_req_oh), .o_rot_idx(w_req_idx), .o_any(w_req_any));
  pic_priority_resolver u_isr (.i_vec(r_isr), .i_amt(w_amt), .o_onehot(w_isr_oh), .o_rot_idx(w_isr_idx), .o_any(w_isr_any));
  assign w_eligible = w_req_any & (~w_isr_any | (w_req_idx < w_isr_idx));
  assign w_ack_rise = int_ack & ~r_int_ack_q;
  assign w_first    = (r_state == IDLE) & w_ack_rise;
  assign w_second   = (r_state == WAIT2) & w_ack_rise;
  assign w_level    = w_eligible ? onehot_to_idx3(w_req_oh) : SPURIOUS_LEVEL;
  assign w_set      = (w_first & w_eligible) ? w_req_oh : 8'h00;
  assign w_aeoi_clr = (w_second & auto_eoi & ~r_spur) ? (8'd1 << r_level) : 8'h00;
  assign w_rise     = ir & ~r_ir_prev;
  always_comb begin
    w_state_next = w_first ? WAIT2 : w_second ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_irr       <= 8'h00;
      r_isr       <= 8'h00;
      r_ir_prev   <= 8'hFF;
      r_ack       <= 8'h00;
      r_vector    <= 8'h00;
      r_int       <= 1'b0;
      r_vv        <= 1'b0;
      r_int_ack_q <= 1'b0;
      r_spur      <= 1'b0;
      r_level     <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_ir_prev   <= ir;
      r_int_ack_q <= int_ack;
      r_irr       <= (level_edge_triggered ? ir : (r_irr | w_rise)) & ~w_set;
      r_isr       <= (r_isr & ~eoi & ~w_aeoi_clr) | w_set;
      r_int       <= (r_state == IDLE) & ~w_first & w_eligible;
      r_vv        <= w_second;
      if (w_first) begin
        r_level <= w_level;
        r_spur  <= ~w_eligible;
        r_ack   <= 8'd1 << w_level;
      end
      if (w_second) r_vector <= {vector_base, r_level};
    end
  end
  assign INT                      = r_int;
  assign irr                      = r_irr;
  assign isr                      = r_isr;
  assign highest_level_in_service = w_isr_oh;
  assign acknowledge_interrupt    = r_ack;
  assign end_of_ack_seq           = r_vv;
  assign vector                   = r_vector;
  assign vector_valid             = r_vv;
endmodule

// File: tb/tb_pic_request_service.sv
// tb_pic_request_service: directed checks of request latching, priority, ack sequencing and reset
module tb_pic_request_service;
  logic       clk = 1'b0, reset = 1'b1, level_edge_triggered = 1'b0, auto_eoi = 1'b0, int_ack = 1'b0;
  logic [7:0] ir = 8'h00, int_mask = 8'h00, eoi = 8'h00;
  logic [2:0] priority_rotate = 3'd7;
  logic [4:0] vector_base = 5'h1A;
  logic       INT, end_of_ack_seq, vector_valid;
  logic [7:0] irr, isr, highest_level_in_service, acknowledge_interrupt, vector;
  int checks = 0, errors = 0;
  pic_request_service dut (
    .clk(clk), .reset(reset), .ir(ir), .level_edge_triggered(level_edge_triggered),
    .int_mask(int_mask), .eoi(eoi), .priority_rotate(priority_rotate), .auto_eoi(auto_eoi),
    .vector_base(vector_base), .int_ack(int_ack), .INT(INT), .irr(irr), .isr(isr),
    .highest_level_in_service(highest_level_in_service), .acknowledge_interrupt(acknowledge_interrupt),
    .end_of_ack_seq(end_of_ack_seq), .vector(vector), .vector_valid(vector_valid)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1; ir = 8'h00; int_ack = 1'b0; eoi = 8'h00; int_mask = 8'h00;
    priority_rotate = 3'd7; auto_eoi = 1'b0; level_edge_triggered = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask
  task automatic ack_pulse();
    int_ack = 1'b1; tick();
    int_ack = 1'b0; tick();
  endtask
  initial begin
    tick(); tick();
    chk("rst_int", {7'd0, INT}, 8'h00);
    chk("rst_irr", irr, 8'h00);
    chk("rst_isr", isr, 8'h00);
    chk("rst_ack", acknowledge_interrupt, 8'h00);
    chk("rst_vec", vector, 8'h00);
    chk("rst_vv", {7'd0, vector_valid}, 8'h00);
    do_reset();
    ir = 8'h24; tick();
    chk("e_irr", irr, 8'h24);
    chk("e_int_lat1", {7'd0, INT}, 8'h00);
    tick();
    chk("e_int_lat2", {7'd0, INT}, 8'h01);
    int_ack = 1'b1; tick();
    chk("a1_isr", isr, 8'h04);
    chk("a1_irr", irr, 8'h20);
    chk("a1_ack", acknowledge_interrupt, 8'h04);
    chk("a1_int", {7'd0, INT}, 8'h00);
    tick();
    chk("held_vv", {7'd0, vector_valid}, 8'h00);
    int_ack = 1'b0; tick();
    int_ack = 1'b1; tick();
    chk("a2_vv", {7'd0, vector_valid}, 8'h01);
    chk("a2_eoas", {7'd0, end_of_ack_seq}, 8'h01);
    chk("a2_vec", vector, 8'hD2);
    int_ack = 1'b0; tick();
    chk("a2_vv_off", {7'd0, vector_valid}, 8'h00);
    chk("hlis_2", highest_level_in_service, 8'h04);
    chk("ir5_blocked", {7'd0, INT}, 8'h00);
    ir = 8'h26; tick(); tick();
    chk("ir1_irr", irr, 8'h22);
    chk("ir1_int", {7'd0, INT}, 8'h01);
    ack_pulse(); ack_pulse();
    chk("ir1_vec", vector, 8'hD1);
    chk("ir1_isr", isr, 8'h06);
    chk("hlis_1", highest_level_in_service, 8'h02);
    eoi = 8'h02; tick(); eoi = 8'h00;
    chk("eoi1_isr", isr, 8'h04);
    tick();
    chk("eoi1_int", {7'd0, INT}, 8'h00);
    eoi = 8'h04; tick(); eoi = 8'h00;
    chk("eoi2_isr", isr, 8'h00);
    tick();
    chk("eoi2_int", {7'd0, INT}, 8'h01);
    do_reset();
    priority_rotate = 3'd4;
    ir = 8'h44; tick(); tick();
    chk("rot_int", {7'd0, INT}, 8'h01);
    ack_pulse();
    chk("rot_ack", acknowledge_interrupt, 8'h40);
    chk("rot_irr", irr, 8'h04);
    chk("rot_hlis", highest_level_in_service, 8'h40);
    ack_pulse();
    chk("rot_vec", vector, 8'hD6);
    chk("rot_int_blk", {7'd0, INT}, 8'h00);
    do_reset();
    ir = 8'h01; tick(); tick();
    chk("msk_int_on", {7'd0, INT}, 8'h01);
    int_mask = 8'h01; tick();
    chk("msk_int_off", {7'd0, INT}, 8'h00);
    int_mask = 8'h00; tick();
    chk("msk_int_back", {7'd0, INT}, 8'h01);
    do_reset();
    ack_pulse();
    chk("sp_ack", acknowledge_interrupt, 8'h80);
    chk("sp_isr", isr, 8'h00);
    ack_pulse();
    chk("sp_vec", vector, 8'hD7);
    chk("sp_isr2", isr, 8'h00);
    do_reset();
    auto_eoi = 1'b1;
    ir = 8'h01; tick(); tick();
    ack_pulse();
    chk("ae_isr1", isr, 8'h01);
    int_ack = 1'b1; tick();
    chk("ae_vv", {7'd0, vector_valid}, 8'h01);
    chk("ae_isr2", isr, 8'h00);
    chk("ae_vec", vector, 8'hD0);
    int_ack = 1'b0; tick();
    chk("ae_eoas_once", {7'd0, end_of_ack_seq}, 8'h00);
    do_reset();
    level_edge_triggered = 1'b1;
    ir = 8'h08; tick();
    chk("lv_irr", irr, 8'h08);
    tick();
    chk("lv_int", {7'd0, INT}, 8'h01);
    ir = 8'h00; tick();
    chk("lv_irr_drop", irr, 8'h00);
    ack_pulse();
    chk("lv_sp_ack", acknowledge_interrupt, 8'h80);
    chk("lv_sp_isr", isr, 8'h00);
    ack_pulse();
    chk("lv_sp_vec", vector, 8'hD7);
    do_reset();
    ir = 8'h10; tick(); tick();
    ack_pulse();
    chk("w2_isr", isr, 8'h10);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("w2r_isr", isr, 8'h00);
    chk("w2r_irr", irr, 8'h00);
    chk("w2r_ack", acknowledge_interrupt, 8'h00);
    chk("w2r_vec", vector, 8'h00);
    chk("w2r_int", {7'd0, INT}, 8'h00);
    int_ack = 1'b1; tick();
    chk("w2r_no_vv", {7'd0, vector_valid}, 8'h00);
    chk("w2r_first", acknowledge_interrupt, 8'h80);
    int_ack = 1'b0; tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
